dac_seq: RTL and testbench
==========================

Name: dac_seq

Overview:
- Parametrised successor to the single-shot DAC controller.
- Cycles round-robin over NCH DAC channels and produces per-channel constant, sawtooth or triangle waveforms.
- Drives the existing SPI DAC driver through its data/address/command/dactrig/dacdone handshake.
- Adds a sweep-rate divider, a handshake timeout and status/debug reporting.

Parameters:
- NCH, 4, number of channels sequenced (1..16); channel i uses DAC address i.
- DW, 12, sample width.
- STEP, 1, ramp/triangle increment per update (1..2^DW-1).
- DIV, 1000, idle cycles between full sweeps (>=1).
- TIMEOUT, 4095, maximum cycles to wait for dacdone after dactrig.

Ports:
- CLK50MHZ  in  1  system clock.
- RST  in  1  reset; asynchronous, active-low.
- en  in  1  run enable; sampled only in IDLE.
- mode  in  2  00 constant, 01 sawtooth, 10 triangle, 11 treated as 00.
- const_val  in  DW  value written in constant mode.
- data  out  DW  sample to the DAC driver.
- address  out  4  DAC channel address.
- command  out  4  DAC command; fixed 4'b0011 (write and update).
- dactrig  out  1  one-cycle start pulse to the driver.
- dacdone  in  1  one-cycle completion pulse from the driver.
- busy  out  1  high outside IDLE.
- err  out  1  sticky; set on timeout.
- debug  out  8  {err, busy, state[2:0], chan[2:0]}.

Behaviour:
- Reset (RST=0, async): state IDLE, chan=0, all value[i]=0, all dir[i]=up, dactrig=0, busy=0, err=0, data=0, address=0, div_cnt=0, to_cnt=0. command is constant 4'b0011.
- Reset mid-transfer: abort immediately to the reset values. No further dactrig is issued until en is seen again.
- States:
  - IDLE: if en=1, go to LOAD with chan=0.
  - LOAD: register data = (mode==01|10) ? value[chan] : const_val; address = chan; next TRIG.
  - TRIG: dactrig=1 for exactly this cycle; to_cnt=0; next WAIT.
  - WAIT: data and address held stable.
    - dacdone=1: go to UPDATE.
    - Else if to_cnt==TIMEOUT-1: err=1, go to UPDATE (the sample counts as sent).
    - Else to_cnt+1.
  - UPDATE: advance value[chan] per mode.
    - If chan==NCH-1: chan=0, div_cnt=0, go to PAUSE.
    - Else chan+1, go to LOAD.
  - PAUSE: count div_cnt to DIV-1, then go to IDLE.
- Latency: the first dactrig occurs 2 cycles after en is sampled high in IDLE. The next channel's dactrig occurs 3 cycles after its dacdone.
- Waveform update (UPDATE state, current channel only):
  - Sawtooth: value = (value+STEP) mod 2^DW.
  - Triangle, dir up: if value > MAX-STEP then value=MAX, dir=down; else value+STEP.
  - Triangle, dir down: if value < STEP then value=0, dir=up; else value-STEP.
  - MAX = 2^DW-1. Arithmetic is done in DW+1 bits, with no silent wrap in triangle mode.
  - Constant mode: value and dir unchanged.
- mode is sampled in LOAD and UPDATE only. A change takes effect at the next channel boundary; stored values are kept.
- dacdone outside WAIT is ignored. dacdone coincident with timeout expiry is treated as done; err is not set.
- err clears only on reset.
- en dropping mid-sweep finishes the sweep and PAUSE, then the block stays in IDLE.

Test Plan:
- Constant, NCH=4, const_val=12'h03f, driver model acks 5 cycles after trig -> four dactrig pulses, address 0,1,2,3, data 12'h03f each, command 4'b0011, then PAUSE of DIV cycles.
- Sawtooth, STEP=1024, DW=12, NCH=1 -> data sequence over successive sweeps: 0, 1024, 2048, 3072, 0 (wrap).
- Triangle, STEP=1500, NCH=1 -> data 0, 1500, 3000, 4095, 2595, 1095, 0, 1500 (saturated turnaround at both ends).
- Driver never asserts dacdone, TIMEOUT=16 -> err=1 exactly 16 cycles after the TRIG cycle; next channel's dactrig follows; err stays high.
- RST pulsed low during WAIT on channel 2 -> all outputs return to reset values asynchronously; after release with en=1, sequencing restarts at address 0, data 0.
- dacdone asserted in the same cycle as timeout expiry, plus a spurious dacdone in LOAD -> err stays 0; the spurious pulse causes no state change.

Source files
------------

// File: rtl/dac_seq_if.sv
// Handshake bundle between the waveform sequencer and the SPI DAC driver.
// The sequencer is the master: it presents a sample, pulses dactrig and waits for dacdone.
interface dac_seq_if #(
  parameter int DW = 12
);
  logic [DW-1:0] data;
  logic [3:0]    address;
  logic [3:0]    command;
  logic          dactrig;
  logic          dacdone;

  modport master (
    output data,
    output address,
    output command,
    output dactrig,
    input  dacdone
  );

  modport slave (
    input  data,
    input  address,
    input  command,
    input  dactrig,
    output dacdone
  );
endinterface

// File: rtl/dac_seq.sv
// Round-robin DAC channel sequencer producing constant, sawtooth or triangle waveforms
// per channel, with a sweep-rate divider, a dacdone timeout and status/debug outputs.
module dac_seq #(
  parameter int NCH     = 4,
  parameter int DW      = 12,
  parameter int STEP    = 1,
  parameter int DIV     = 1000,
  parameter int TIMEOUT = 4095
) (
  input  logic          CLK50MHZ,
  input  logic          RST,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] const_val,
  dac_seq_if.master     dac,
  output logic          busy,
  output logic          err,
  output logic [7:0]    debug
);

  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NSLOT = 2 ** CHW;
  localparam int TOW   = $clog2(TIMEOUT + 1);
  localparam int DVW   = $clog2(DIV + 1);
  localparam int DW1   = DW + 1;

  localparam logic [3:0]     LAST_CH  = 4'(NCH - 1);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
  localparam logic [DW:0]    STEP_W   = DW1'(STEP);
  localparam logic [DW:0]    MAX_W    = {1'b0, {DW{1'b1}}};
  localparam logic [DW:0]    UP_LIMIT = MAX_W - STEP_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_TRIG   = 3'd2,
    S_WAIT   = 3'd3,
    S_UPDATE = 3'd4,
    S_PAUSE  = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      chan;
  logic [DW-1:0]   value [NSLOT];
  logic            dir   [NSLOT];
  logic [DW-1:0]   data_r;
  logic [3:0]      addr_r;
  logic            trig_r;
  logic            err_r;
  logic [TOW-1:0]  to_cnt;
  logic [DVW-1:0]  div_cnt;

  logic [CHW-1:0]  idx;
  logic            use_wave;
  logic            timeout_hit;
  logic [DW:0]     cur;
  logic [DW-1:0]   nxt_val;
  logic            nxt_dir;

  assign idx         = chan[CHW-1:0];
  assign use_wave    = (mode == 2'b01) || (mode == 2'b10);
  assign timeout_hit = (to_cnt == TO_LAST);
  assign cur         = {1'b0, value[idx]};

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (en) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_TRIG;
      S_TRIG:   state_nx = S_WAIT;
      // A done pulse on the expiry cycle still counts as a normal completion.
      S_WAIT:   if (dac.dacdone || timeout_hit) state_nx = S_UPDATE;
      S_UPDATE: state_nx = (chan == LAST_CH) ? S_PAUSE : S_LOAD;
      S_PAUSE:  if (div_cnt == DIV_LAST) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Triangle arithmetic runs one bit wider so the turnaround saturates instead of wrapping.
  always_comb begin
    nxt_val = value[idx];
    nxt_dir = dir[idx];
    case (mode)
      2'b01: nxt_val = DW'(cur + STEP_W);
      2'b10: begin
        if (!dir[idx]) begin
          if (cur > UP_LIMIT) begin
            nxt_val = MAX_W[DW-1:0];
            nxt_dir = 1'b1;
          end else begin
            nxt_val = DW'(cur + STEP_W);
          end
        end else begin
          if (cur < STEP_W) begin
            nxt_val = '0;
            nxt_dir = 1'b0;
          end else begin
            nxt_val = DW'(cur - STEP_W);
          end
        end
      end
      default: begin
        nxt_val = value[idx];
        nxt_dir = dir[idx];
      end
    endcase
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      chan    <= '0;
      data_r  <= '0;
      addr_r  <= '0;
      trig_r  <= 1'b0;
      err_r   <= 1'b0;
      to_cnt  <= '0;
      div_cnt <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        value[i] <= '0;
        dir[i]   <= 1'b0;
      end
    end else begin
      trig_r <= (state_nx == S_TRIG);
      case (state)
        S_IDLE: if (en) chan <= '0;
        S_LOAD: begin
          data_r <= use_wave ? value[idx] : const_val;
          addr_r <= chan;
        end
        S_TRIG: to_cnt <= '0;
        S_WAIT: begin
          if (!dac.dacdone) begin
            if (timeout_hit) err_r  <= 1'b1;
            else             to_cnt <= to_cnt + 1'b1;
          end
        end
        S_UPDATE: begin
          value[idx] <= nxt_val;
          dir[idx]   <= nxt_dir;
          if (chan == LAST_CH) begin
            chan    <= '0;
            div_cnt <= '0;
          end else begin
            chan <= chan + 4'd1;
          end
        end
        S_PAUSE: if (div_cnt != DIV_LAST) div_cnt <= div_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign dac.data    = data_r;
  assign dac.address = addr_r;
  assign dac.command = 4'b0011;
  assign dac.dactrig = trig_r;
  assign busy        = (state != S_IDLE);
  assign err         = err_r;
  assign debug       = {err_r, busy, state, chan[2:0]};

endmodule

// File: tb/tb_dac_seq.sv
// Scoreboard bench for dac_seq: a driver model acks each dactrig, expected samples are
// queued per sweep from a reference waveform model and popped on every dactrig.
module tb_dac_seq;

  localparam int NCH     = 4;
  localparam int DW      = 12;
  localparam int STEP    = 1500;
  localparam int DIV     = 8;
  localparam int TIMEOUT = 16;
  localparam int MAXV    = (1 << DW) - 1;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_TRIG = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;

  logic          CLK50MHZ = 1'b0;
  logic          RST = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] const_val = '0;
  logic          busy;
  logic          err;
  logic [7:0]    debug;

  dac_seq_if #(.DW(DW)) dac ();

  dac_seq #(
    .NCH(NCH), .DW(DW), .STEP(STEP), .DIV(DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK50MHZ (CLK50MHZ),
    .RST      (RST),
    .en       (en),
    .mode     (mode),
    .const_val(const_val),
    .dac      (dac),
    .busy     (busy),
    .err      (err),
    .debug    (debug)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  int m_val[NCH];
  bit m_dir[NCH];

  int ack_delay = 5;
  int ack_cnt = 0;
  bit spur_req = 0;
  bit spur_chk = 0;
  int cyc = 0;
  int en_cyc = 0;
  int done_cyc = 0;
  int trig_cyc = 0;
  int trig_count = 0;
  bit got_done = 0;
  logic err_prev = 1'b0;
  logic busy_prev = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelUpdate(input int ch, input logic [1:0] m);
    int v;
    v = m_val[ch];
    if (m == 2'b01) begin
      v = (v + STEP) % (MAXV + 1);
    end else if (m == 2'b10) begin
      if (!m_dir[ch]) begin
        if (v + STEP > MAXV) begin v = MAXV; m_dir[ch] = 1'b1; end
        else v = v + STEP;
      end else begin
        if (v - STEP < 0) begin v = 0; m_dir[ch] = 1'b0; end
        else v = v - STEP;
      end
    end
    m_val[ch] = v;
  endfunction

  task automatic pushSweep(input logic [1:0] m, input logic [DW-1:0] cv);
    logic [DW-1:0] d;
    for (int ch = 0; ch < NCH; ch++) begin
      d = (m == 2'b01 || m == 2'b10) ? DW'(m_val[ch]) : cv;
      exp_q.push_back({4'(ch), d});
      modelUpdate(ch, m);
    end
  endtask

  // Driver model and output monitor share one process so dacdone and its timestamp agree.
  always @(negedge CLK50MHZ) begin
    logic [15:0] e;
    cyc++;
    if (!RST) begin
      ack_cnt = 0;
      got_done = 0;
      dac.dacdone = 1'b0;
    end else begin
      dac.dacdone = 1'b0;
      if (spur_chk) begin
        checkOutput("spurious_done_ignored", debug[5:3], ST_TRIG);
        spur_chk = 0;
      end
      if (dac.dactrig) begin
        if (exp_q.size() == 0) begin
          checkOutput("trig_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("data", dac.data, e[11:0]);
          checkOutput("address", dac.address, e[15:12]);
          checkOutput("command", dac.command, 4'b0011);
          if (e[15:12] == 4'd0)  checkOutput("first_trig_latency", cyc - en_cyc, 2);
          else if (got_done)     checkOutput("done_to_trig", cyc - done_cyc, 3);
          else                   checkOutput("timeout_to_trig", cyc - trig_cyc, TIMEOUT + 3);
        end
        trig_cyc = cyc;
        got_done = 0;
        trig_count++;
        if (ack_delay > 0) ack_cnt = ack_delay;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          dac.dacdone = 1'b1;
          done_cyc = cyc;
          got_done = 1;
        end
      end else if (spur_req && debug[5:3] == ST_LOAD) begin
        dac.dacdone = 1'b1;
        spur_req = 0;
        spur_chk = 1;
      end
      if (err && !err_prev) checkOutput("err_rise_delay", cyc - trig_cyc, TIMEOUT + 1);
      if (!busy && busy_prev && got_done) checkOutput("pause_length", cyc - done_cyc, DIV + 2);
    end
    err_prev = err;
    busy_prev = busy;
  end

  task automatic applyReset();
    @(negedge CLK50MHZ);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("rst_data", dac.data, 0);
    checkOutput("rst_address", dac.address, 0);
    checkOutput("rst_dactrig", dac.dactrig, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_debug", debug, 0);
    checkOutput("rst_command", dac.command, 4'b0011);
    exp_q.delete();
    for (int ch = 0; ch < NCH; ch++) begin
      m_val[ch] = 0;
      m_dir[ch] = 1'b0;
    end
    repeat (2) @(negedge CLK50MHZ);
    #1;
    RST = 1'b1;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [DW-1:0] cv,
                               input int sweeps, input int ack);
    int t;
    ack_delay = ack;
    mode = m;
    const_val = cv;
    for (int s = 0; s < sweeps; s++) begin
      pushSweep(m, cv);
      @(negedge CLK50MHZ);
      #1;
      en = 1'b1;
      en_cyc = cyc;
      t = 0;
      while (!busy && t < 10) begin @(negedge CLK50MHZ); #1; t++; end
      if (!busy) checkOutput("busy_rise", 0, 1);
      en = 1'b0;
      t = 0;
      while (busy && t < 3000) begin @(negedge CLK50MHZ); #1; t++; end
      if (busy) checkOutput("busy_fall", 1, 0);
      checkOutput("queue_drained", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int t;
    int tc0;
    dac.dacdone = 1'b0;
    repeat (2) @(negedge CLK50MHZ);
    applyReset();

    applyStimulus(2'b00, 12'h03f, 1, 5);
    applyStimulus(2'b01, '0, 4, 5);
    applyStimulus(2'b11, 12'h5a5, 1, 5);
    applyStimulus(2'b01, '0, 1, 5);

    // Done coincident with timeout expiry, plus a stray done while in LOAD.
    @(negedge CLK50MHZ);
    #1;
    spur_req = 1;
    applyStimulus(2'b00, 12'h123, 1, TIMEOUT);
    checkOutput("err_coincident", err, 0);

    applyStimulus(2'b00, 12'h7ff, 1, 0);
    checkOutput("err_set_on_timeout", err, 1);
    applyStimulus(2'b00, 12'h001, 1, 5);
    checkOutput("err_sticky", err, 1);

    // Abort while channel 2 is waiting for its done.
    ack_delay = 10;
    mode = 2'b10;
    pushSweep(2'b10, '0);
    @(negedge CLK50MHZ);
    #1;
    tc0 = trig_count;
    en = 1'b1;
    en_cyc = cyc;
    t = 0;
    while (trig_count < tc0 + 3 && t < 500) begin @(negedge CLK50MHZ); #1; t++; end
    checkOutput("reach_ch2", trig_count - tc0, 3);
    en = 1'b0;
    repeat (3) @(negedge CLK50MHZ);
    #1;
    checkOutput("ch2_waiting", debug[5:3], ST_WAIT);
    applyReset();
    repeat (10) @(negedge CLK50MHZ);
    #1;
    checkOutput("no_trig_after_reset", trig_count - tc0, 3);

    applyStimulus(2'b10, '0, 8, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
